// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: op encodings,
// FSM state type and iteration count.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// fixed 34-edge latency from accepted start to done pulse.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int DW = 2 * XLEN;

  mdu_state_t r_state;
  mdu_state_t w_state_next;

  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [DW-1:0]   r_acc;
  logic [XLEN-1:0] r_opb;
  logic [4:0]      r_cnt;
  logic [1:0]      r_op;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_div0;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  logic [XLEN:0]   w_mul_sum;
  logic [DW-1:0]   w_mul_next;
  logic [XLEN:0]   w_div_top;
  logic            w_div_ge;
  logic [XLEN-1:0] w_div_diff;
  logic [DW-1:0]   w_div_next;
  logic [DW-1:0]   w_acc_step;

  logic [DW-1:0]   w_prod_fix;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_hi_fix;
  logic [XLEN-1:0] w_lo_fix;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand conditioning at launch: work on magnitudes, remember result signs.
  assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_a_neg  = w_signed & rs_data[XLEN-1];
  assign w_b_neg  = w_signed & rt_data[XLEN-1];
  assign w_a_mag  = w_a_neg ? -rs_data : rs_data;
  assign w_b_mag  = w_b_neg ? -rt_data : rt_data;

  // Multiply step: acc = {partial product, unconsumed multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[DW-1:XLEN]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[DW-1:XLEN], r_acc[XLEN-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  // The shifted remainder needs 33 bits; the difference fits 32 whenever it is kept.
  assign w_div_top  = r_acc[DW-1:XLEN-1];
  assign w_div_ge   = (w_div_top >= {1'b0, r_opb});
  assign w_div_diff = w_div_top[XLEN-1:0] - r_opb;
  assign w_div_next = w_div_ge ? {w_div_diff, r_acc[XLEN-2:0], 1'b1}
                               : {r_acc[DW-2:0], 1'b0};

  assign w_acc_step = r_op[1] ? w_div_next : w_mul_next;

  // A zero divisor runs the full loop; only the quotient is forced afterwards.
  always_comb begin
    w_prod_fix = r_neg_res ? -r_acc : r_acc;
    w_rem_fix  = r_neg_rem ? -r_acc[DW-1:XLEN] : r_acc[DW-1:XLEN];
    w_quo_fix  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    if (r_div0) begin
      w_quo_fix = '1;
    end
    w_hi_fix = w_rem_fix;
    w_lo_fix = w_quo_fix;
    case (r_op)
      MDU_MULT, MDU_MULTU: begin
        w_hi_fix = w_prod_fix[DW-1:XLEN];
        w_lo_fix = w_prod_fix[XLEN-1:0];
      end
      default: begin
        w_hi_fix = w_rem_fix;
        w_lo_fix = w_quo_fix;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MDU_IDLE: if (start) w_state_next = MDU_CALC;
      MDU_CALC: if (r_cnt == 5'(MDU_ITERS - 1)) w_state_next = MDU_FIX;
      MDU_FIX:  w_state_next = MDU_IDLE;
      default:  w_state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MDU_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != MDU_IDLE);
      r_done  <= (r_state == MDU_FIX);
    end
  end

  // Datapath and architectural HI/LO; only FIX or an idle move touches hi/lo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_op      <= MDU_MULT;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (start) begin
            r_acc     <= {{XLEN{1'b0}}, w_a_mag};
            r_opb     <= w_b_mag;
            r_cnt     <= '0;
            r_op      <= op;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_div0    <= (rt_data == '0);
          end else begin
            if (mthi) r_hi <= rs_data;
            if (mtlo) r_lo <= rs_data;
          end
        end
        MDU_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 5'd1;
        end
        MDU_FIX: begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
